// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [1:0] TLEN_5 = 2'b00;
    localparam logic [1:0] TLEN_6 = 2'b01;
    localparam logic [1:0] TLEN_7 = 2'b10;
    localparam logic [1:0] TLEN_8 = 2'b11;

    localparam int unsigned OS16 = 16;
    localparam int unsigned OS12 = 12;

    // Index of the final data bit for a given length code (5..8 bits).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] tlen);
        return {1'b0, tlen} + 3'd4;
    endfunction

    // Parity bit the transmitter must have sent; even parity makes the total count of ones even.
    function automatic logic exp_parity(input logic [7:0] data, input logic odd);
        return odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/rsr_sample_ctr.sv
// RX input synchronizer, falling-edge detector and oversample tick counter.
module rsr_sample_ctr
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    input  logic clr,
    input  logic os12,
    output logic rx_sync,
    output logic rx_fall,
    output logic mid_start,
    output logic mid_bit
);

    localparam logic [3:0] HALF16 = 4'(OS16 / 2 - 1);
    localparam logic [3:0] HALF12 = 4'(OS12 / 2 - 1);
    localparam logic [3:0] LAST16 = 4'(OS16 - 1);
    localparam logic [3:0] LAST12 = 4'(OS12 - 1);

    logic       rx_meta;
    logic       rx_prev;
    logic [3:0] cnt;
    logic [3:0] half_tick;
    logic [3:0] last_tick;

    // Synchronizer resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        half_tick = os12 ? HALF12 : HALF16;
        last_tick = os12 ? LAST12 : LAST16;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == last_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    assign rx_fall   = rx_prev & ~rx_sync;
    assign mid_start = (cnt == half_tick);
    assign mid_bit   = (cnt == last_tick);

endmodule

// File: rtl/rsr_reg.sv
// UART receive shift register: start detect, mid-bit data sampling, parity/stop check, FIFO write strobe.
module rsr_reg
    import uart_pkg::*;
(
    input  logic       btick_16,
    input  logic       rst_n,
    input  logic       btick,
    input  logic [1:0] tlen,
    input  logic       fifo_nfull,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       sample_type,
    input  logic       rx_in,
    output logic       wr_en,
    output logic       frame_err,
    output logic [7:0] rdata,
    output logic       parity_err
);

    rx_state_e  state;
    logic [1:0] tlen_q;
    logic       par_en_q;
    logic       par_odd_q;
    logic       os12_q;
    logic [2:0] bit_idx;
    logic [7:0] data_q;
    logic       par_bit_q;

    logic       rx_sync;
    logic       rx_fall;
    logic       mid_start;
    logic       mid_bit;
    logic       clr;
    logic       unused_btick;

    assign unused_btick = btick;

    // Counter restarts at start detect and again once the start bit is confirmed.
    always_comb begin
        clr = 1'b0;
        if (state == IDLE && rx_fall)
            clr = 1'b1;
        else if (state == START && mid_start && !rx_sync)
            clr = 1'b1;
    end

    rsr_sample_ctr u_sample_ctr (
        .clk       (btick_16),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .clr       (clr),
        .os12      (os12_q),
        .rx_sync   (rx_sync),
        .rx_fall   (rx_fall),
        .mid_start (mid_start),
        .mid_bit   (mid_bit)
    );

    always_ff @(posedge btick_16 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tlen_q     <= TLEN_5;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            os12_q     <= 1'b0;
            bit_idx    <= '0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            rdata      <= '0;
            wr_en      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_fall) begin
                        tlen_q    <= tlen;
                        par_en_q  <= parity_en;
                        par_odd_q <= parity_type;
                        os12_q    <= sample_type;
                        bit_idx   <= '0;
                        data_q    <= '0;
                        par_bit_q <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (mid_start)
                        state <= rx_sync ? IDLE : DATA;
                end
                DATA: begin
                    if (mid_bit) begin
                        data_q[bit_idx] <= rx_sync;
                        if (bit_idx == last_bit_idx(tlen_q))
                            state <= par_en_q ? PARITY : STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                PARITY: begin
                    if (mid_bit) begin
                        par_bit_q <= rx_sync;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (mid_bit) begin
                        rdata      <= data_q;
                        frame_err  <= ~rx_sync;
                        parity_err <= par_en_q & (par_bit_q != exp_parity(data_q, par_odd_q));
                        wr_en      <= fifo_nfull;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsr_reg.sv
// Directed frame bench for rsr_reg with a frame-level reference model and per-cycle output check.
module tb_rsr_reg;

    logic       btick_16 = 1'b0;
    logic       rst_n = 1'b0;
    logic       btick = 1'b0;
    logic [1:0] tlen = 2'b11;
    logic       fifo_nfull = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       sample_type = 1'b0;
    logic       rx_in = 1'b1;
    logic       wr_en;
    logic       frame_err;
    logic [7:0] rdata;
    logic       parity_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: what the outputs must show between frames.
    logic [7:0]  m_rdata = 8'h00;
    logic        m_fe = 1'b0;
    logic        m_pe = 1'b0;
    logic        settle = 1'b0;
    logic        run = 1'b0;
    int unsigned wr_cnt = 0;

    rsr_reg dut (
        .btick_16    (btick_16),
        .rst_n       (rst_n),
        .btick       (btick),
        .tlen        (tlen),
        .fifo_nfull  (fifo_nfull),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .sample_type (sample_type),
        .rx_in       (rx_in),
        .wr_en       (wr_en),
        .frame_err   (frame_err),
        .rdata       (rdata),
        .parity_err  (parity_err)
    );

    always #5 btick_16 = ~btick_16;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic hold(input int unsigned n);
        repeat (n) @(posedge btick_16);
        #1;
    endtask

    // Outside the stop-bit window outputs must match the model and wr_en must stay low.
    always @(negedge btick_16) begin
        if (run) begin
            if (settle) begin
                if (wr_en === 1'b1) wr_cnt++;
            end else begin
                check("wr_en_quiet", {7'd0, wr_en}, 8'h00);
                check("rdata_model", rdata, m_rdata);
                check("frame_err_model", {7'd0, frame_err}, {7'd0, m_fe});
                check("parity_err_model", {7'd0, parity_err}, {7'd0, m_pe});
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic [1:0] tl, input logic pen,
                              input logic podd, input logic os12, input logic flip_par,
                              input logic stop_lvl, input logic nfull);
        int unsigned n;
        int unsigned nb;
        logic [7:0]  md;
        logic        pbit;
        n  = os12 ? 12 : 16;
        nb = int'(tl) + 5;
        md = d & 8'((1 << nb) - 1);
        // Parity bit by counting ones: even -> count of ones stays even overall.
        pbit = (($countones(md) % 2) == (podd ? 0 : 1)) ^ flip_par;
        tlen = tl; parity_en = pen; parity_type = podd; sample_type = os12; fifo_nfull = nfull;
        hold(n);
        wr_cnt = 0;
        rx_in = 1'b0;
        hold(n - 2);
        tlen = ~tl; parity_en = ~pen; parity_type = ~podd; sample_type = ~os12;
        hold(2);
        for (int i = 0; i < int'(nb); i++) begin
            rx_in = md[i];
            hold(n);
        end
        if (pen) begin
            rx_in = pbit;
            hold(n);
        end
        settle = 1'b1;
        rx_in = stop_lvl;
        hold(n);
        rx_in = 1'b1;
        hold(4);
        check("wr_en_pulses", 8'(wr_cnt), nfull ? 8'd1 : 8'd0);
        m_rdata = md;
        m_fe = ~stop_lvl;
        m_pe = pen & flip_par;
        settle = 1'b0;
        tlen = tl; parity_en = pen; parity_type = podd; sample_type = os12;
        hold(2 * n);
    endtask

    initial begin
        hold(4);
        rst_n = 1'b1;
        hold(2);
        check("reset_rdata", rdata, 8'h00);
        check("reset_wr_en", {7'd0, wr_en}, 8'h00);
        check("reset_frame_err", {7'd0, frame_err}, 8'h00);
        check("reset_parity_err", {7'd0, parity_err}, 8'h00);
        run = 1'b1;
        hold(20);

        send_frame(8'hEB, TLEN_8_c(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("lit_rdata_EB", rdata, 8'hEB);
        check("lit_fe_EB", {7'd0, frame_err}, 8'h00);

        send_frame(8'hFA, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("lit_rdata_FA", rdata, 8'hFA);
        check("lit_fe_FA", {7'd0, frame_err}, 8'h00);

        send_frame(8'h22, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("lit_pe_even_ok", {7'd0, parity_err}, 8'h00);
        send_frame(8'h22, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("lit_pe_even_bad", {7'd0, parity_err}, 8'h01);
        send_frame(8'h22, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("lit_pe_odd_ok", {7'd0, parity_err}, 8'h00);

        send_frame(8'h15, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_rdata_15", rdata, 8'h15);
        check("lit_fe_15", {7'd0, frame_err}, 8'h01);
        send_frame(8'h15, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("lit_fe_15_nfull", {7'd0, frame_err}, 8'h01);

        send_frame(8'hFF, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("lit_rdata_6bit", rdata, 8'h3F);
        send_frame(8'hAA, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("lit_rdata_7bit", rdata, 8'h2A);
        check("lit_pe_7bit", {7'd0, parity_err}, 8'h01);

        // False start: short low pulse must leave outputs untouched.
        rx_in = 1'b0;
        hold(4);
        rx_in = 1'b1;
        hold(48);
        check("lit_false_start_rdata", rdata, 8'h2A);
        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("lit_after_false_start", rdata, 8'h5A);

        // Reset in the middle of a frame.
        settle = 1'b1;
        rx_in = 1'b0;
        hold(40);
        rst_n = 1'b0;
        hold(2);
        check("midframe_reset_rdata", rdata, 8'h00);
        check("midframe_reset_wr_en", {7'd0, wr_en}, 8'h00);
        m_rdata = 8'h00; m_fe = 1'b0; m_pe = 1'b0;
        rx_in = 1'b1;
        rst_n = 1'b1;
        hold(4);
        settle = 1'b0;
        hold(8);
        send_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("lit_rdata_C3", rdata, 8'hC3);

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [1:0] TLEN_8_c();
        return 2'b11;
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
